// File: rtl/mult_booth_seq_if.sv
// Bus bundle for the radix-4 sequential Booth multiplier: start/operands, decoder loop, results.
// Optional data_resultHi exists only when MULT_RESULT_HI_EN is defined.
interface mult_booth_seq_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [2:0]  booth_select;
  logic        addM;
  logic        add2M;
  logic        subM;
  logic        sub2M;
  logic        doNothing;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef MULT_RESULT_HI_EN
  logic [31:0] data_resultHi;
`endif

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    output addM, add2M, subM, sub2M, doNothing,
    input  booth_select, data_result, data_exception, data_resultRDY, busy
`ifdef MULT_RESULT_HI_EN
    , input data_resultHi
`endif
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    input  addM, add2M, subM, sub2M, doNothing,
    output booth_select, data_result, data_exception, data_resultRDY, busy
`ifdef MULT_RESULT_HI_EN
    , output data_resultHi
`endif
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Radix-4 sequential Booth multiplier, 16 iterations, external Booth decoder via booth_select.
// Define MULT_RESULT_HI_EN to add the data_resultHi output (product bits [63:32]).
module mult_booth_seq (
  input logic             clock,
  input logic             resetn,
  mult_booth_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic signed [31:0] m;
  logic signed [33:0] acc;
  logic [31:0]        q;
  logic               q_1;
  logic [4:0]         cnt;
  logic               fault;
  logic [31:0]        result;
  logic               exception;
`ifdef MULT_RESULT_HI_EN
  logic [31:0]        result_hi;
`endif

  logic [4:0]         decode;
  logic               decode_ok;
  logic               last_iter;
  logic signed [33:0] m_ext;
  logic signed [33:0] addend;
  logic signed [33:0] acc_sum;
  logic signed [33:0] acc_next;
  logic [31:0]        q_next;
  logic               q_1_next;
  logic               fault_next;
  logic [32:0]        prod_top;

  assign decode    = {bus.addM, bus.add2M, bus.subM, bus.sub2M, bus.doNothing};
  assign decode_ok = $onehot(decode);
  assign last_iter = (cnt == 5'd15);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ctrl_MULT) state_next = RUN;
      RUN:     if (last_iter)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A malformed decoder response contributes nothing and is remembered as a fault.
  always_comb begin
    m_ext  = {{2{m[31]}}, m};
    addend = '0;
    if (decode_ok) begin
      if (bus.addM)       addend = m_ext;
      else if (bus.add2M) addend = m_ext <<< 1;
      else if (bus.subM)  addend = -m_ext;
      else if (bus.sub2M) addend = -(m_ext <<< 1);
    end
    acc_sum    = acc + addend;
    acc_next   = {{2{acc_sum[33]}}, acc_sum[33:2]};
    q_next     = {acc_sum[1:0], q[31:2]};
    q_1_next   = q[1];
    fault_next = fault | ~decode_ok;
    prod_top   = {acc_next[31:0], q_next[31]};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      fault     <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
`ifdef MULT_RESULT_HI_EN
      result_hi <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ctrl_MULT) begin
            m     <= bus.data_operandA;
            acc   <= '0;
            q     <= bus.data_operandB;
            q_1   <= 1'b0;
            cnt   <= '0;
            fault <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q_1_next;
          cnt   <= cnt + 5'd1;
          fault <= fault_next;
          // Results are captured on the final iteration edge, i.e. on entry to DONE.
          if (last_iter) begin
            result    <= q_next;
            exception <= fault_next | ~((&prod_top) | ~(|prod_top));
`ifdef MULT_RESULT_HI_EN
            result_hi <= acc_next[31:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.booth_select   = (state == RUN) ? {q[1], q[0], q_1} : 3'b000;
  assign bus.data_result    = result;
  assign bus.data_exception = exception;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);
`ifdef MULT_RESULT_HI_EN
  assign bus.data_resultHi  = result_hi;
`endif

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq with a behavioural radix-4 Booth decoder and fault injection.
// Checks the data_resultHi output as well when built with MULT_RESULT_HI_EN.
module tb_mult_booth_seq;

  logic clock;
  logic resetn;
  logic inject;
  int   tests;
  int   failures;

  mult_booth_seq_if bus ();

  mult_booth_seq dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural decoder; inject forces the illegal addM+subM combination.
  always_comb begin
    bus.addM      = 1'b0;
    bus.add2M     = 1'b0;
    bus.subM      = 1'b0;
    bus.sub2M     = 1'b0;
    bus.doNothing = 1'b0;
    case (bus.booth_select)
      3'b001, 3'b010: bus.addM      = 1'b1;
      3'b011:         bus.add2M     = 1'b1;
      3'b100:         bus.sub2M     = 1'b1;
      3'b101, 3'b110: bus.subM      = 1'b1;
      default:        bus.doNothing = 1'b1;
    endcase
    if (inject) begin
      bus.addM      = 1'b1;
      bus.subM      = 1'b1;
      bus.add2M     = 1'b0;
      bus.sub2M     = 1'b0;
      bus.doNothing = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Cycles count clock edges starting with the start edge itself; a reset_cycle aborts the run.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int glitch_cycle, input logic [31:0] glitch_a,
                               input int fault_cycle, input int reset_cycle,
                               output int cycles, output time start_time,
                               output logic [2:0] first_sel);
    int  guard;
    bit  aborted;
    guard   = 0;
    aborted = 1'b0;
    @(negedge clock);
    while (bus.busy && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    resetn            = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    start_time = $time;
    #1;
    bus.ctrl_MULT = 1'b0;
    first_sel     = bus.booth_select;
    cycles        = 1;
    while (!bus.data_resultRDY && cycles < 40 && !aborted) begin
      @(negedge clock);
      if (cycles + 1 == glitch_cycle) begin
        bus.data_operandA = glitch_a;
        bus.ctrl_MULT     = 1'b1;
      end else begin
        bus.ctrl_MULT = 1'b0;
      end
      inject = (cycles + 1 == fault_cycle);
      if (cycles + 1 == reset_cycle) begin
        resetn  = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        cycles++;
      end
    end
    bus.ctrl_MULT = 1'b0;
    inject        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         cycles;
    int         busy_seen;
    time        t_first;
    time        t_second;
    logic [2:0] sel;

    tests             = 0;
    failures          = 0;
    resetn            = 1'b0;
    inject            = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_result", bus.data_result, 64'h0);
    checkOutput("reset_exception", bus.data_exception, 64'h0);
    checkOutput("reset_rdy", bus.data_resultRDY, 64'h0);
    checkOutput("reset_busy", bus.busy, 64'h0);
    checkOutput("reset_sel", bus.booth_select, 64'h0);
`ifdef MULT_RESULT_HI_EN
    checkOutput("reset_hi", bus.data_resultHi, 64'h0);
`endif

    applyStimulus(32'd3, 32'd4, 0, '0, 0, 0, cycles, t_first, sel);
    checkOutput("3x4_latency", cycles, 64'd17);
    checkOutput("3x4_result", bus.data_result, 64'h0000000C);
    checkOutput("3x4_exception", bus.data_exception, 64'h0);
    checkOutput("3x4_busy_done", bus.busy, 64'h1);

    applyStimulus(-32'sd7, 32'd6, 0, '0, 0, 0, cycles, t_second, sel);
    checkOutput("b2b_interval", t_second - t_first, 64'd180);
    checkOutput("m7x6_first_sel", sel, 64'h4);
    checkOutput("m7x6_latency", cycles, 64'd17);
    checkOutput("m7x6_result", bus.data_result, 64'hFFFFFFD6);
    checkOutput("m7x6_exception", bus.data_exception, 64'h0);
`ifdef MULT_RESULT_HI_EN
    checkOutput("m7x6_hi", bus.data_resultHi, 64'hFFFFFFFF);
`endif
    @(posedge clock);
    #1;
    checkOutput("m7x6_rdy_drop", bus.data_resultRDY, 64'h0);
    checkOutput("m7x6_hold", bus.data_result, 64'hFFFFFFD6);

    applyStimulus(32'h80000000, 32'hFFFFFFFF, 0, '0, 0, 0, cycles, t_first, sel);
    checkOutput("minxm1_result", bus.data_result, 64'h80000000);
    checkOutput("minxm1_exception", bus.data_exception, 64'h1);
`ifdef MULT_RESULT_HI_EN
    checkOutput("minxm1_hi", bus.data_resultHi, 64'h00000000);
`endif

    applyStimulus(32'h00010000, 32'h00010000, 0, '0, 0, 0, cycles, t_first, sel);
    checkOutput("2p16sq_result", bus.data_result, 64'h0);
    checkOutput("2p16sq_exception", bus.data_exception, 64'h1);
`ifdef MULT_RESULT_HI_EN
    checkOutput("2p16sq_hi", bus.data_resultHi, 64'h00000001);
`endif

    applyStimulus(32'd5, 32'd5, 5, 32'd9, 0, 0, cycles, t_first, sel);
    checkOutput("ignore_latency", cycles, 64'd17);
    checkOutput("ignore_result", bus.data_result, 64'd25);
    checkOutput("ignore_exception", bus.data_exception, 64'h0);
    busy_seen = 0;
    repeat (2) @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.busy || bus.data_resultRDY) busy_seen++;
    end
    checkOutput("ignore_no_restart", busy_seen, 64'd0);

    applyStimulus(32'd3, 32'd4, 0, '0, 0, 8, cycles, t_first, sel);
    checkOutput("abort_cycle", cycles, 64'd7);
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      if (bus.busy || bus.data_resultRDY) busy_seen++;
    end
    checkOutput("abort_no_activity", busy_seen, 64'd0);
    checkOutput("abort_result", bus.data_result, 64'h0);
    checkOutput("abort_exception", bus.data_exception, 64'h0);
    checkOutput("abort_sel", bus.booth_select, 64'h0);

    applyStimulus(32'd2, -32'sd3, 0, '0, 0, 0, cycles, t_first, sel);
    checkOutput("2xm3_latency", cycles, 64'd17);
    checkOutput("2xm3_result", bus.data_result, 64'hFFFFFFFA);
    checkOutput("2xm3_exception", bus.data_exception, 64'h0);
`ifdef MULT_RESULT_HI_EN
    checkOutput("2xm3_hi", bus.data_resultHi, 64'hFFFFFFFF);
`endif

    applyStimulus(32'd3, 32'd4, 0, '0, 4, 0, cycles, t_first, sel);
    checkOutput("fault_exception", bus.data_exception, 64'h1);
    checkOutput("fault_result", bus.data_result, 64'h0000000C);

    applyStimulus(32'd3, 32'd4, 0, '0, 0, 0, cycles, t_first, sel);
    checkOutput("fault_cleared", bus.data_exception, 64'h0);
    checkOutput("fault_cleared_result", bus.data_result, 64'h0000000C);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
